game_seq_ctrl: RTL and testbench
================================

Name: game_seq_ctrl

Overview:
Coin/credit/start/game-time sequencer for the Space Race discrete-logic core, replacing the original coin latch, credit counter and 555 game-timer network with one synchronous controller. It runs on the fast drive clock, debounces the coin switch and counts credits. It sequences ATTRACT -> CLEAR -> PLAY -> END and drives the attract/game-on levels. These levels gate the rocket, score and time-bar logic.

Parameters:
GAME_FRAMES, 2700, play length in frames (45 s at 60 Hz)
END_FRAMES, 120, game-over hold in frames before returning to attract
COIN_DEBOUNCE, 4, consecutive identical COIN samples needed to change debounced level (>=1)
MAX_CREDITS, 9, credit saturation value (<=15)
TIME_WIDTH, 12, width of frame timer (must hold GAME_FRAMES and END_FRAMES)

Ports:
CLK_DRV  in  1  drive clock; all state changes on rising edge
RST_N  in  1  synchronous reset, active low
COIN  in  1  raw coin switch level, active high
START  in  1  start button level, active high
VBLANK  in  1  vertical blank level; each 0->1 transition is one frame tick
CREDIT_CNT  out  4  current credits
ATTRACT  out  1  high in every state except PLAY
ATTRACT_N  out  1  always ~ATTRACT
GAME_ON  out  1  high in PLAY only
SCORE_CLR  out  1  high for exactly the one CLEAR cycle
GAME_END  out  1  one-cycle pulse on PLAY->END transition
TIME_LEFT  out  TIME_WIDTH  remaining play frames (0 outside PLAY/CLEAR)

Behaviour:
- Clock CLK_DRV only; reset synchronous and active-low (RST_N), sampled on CLK_DRV rising edge.
- Reset (any state, including mid-game): state ATTRACT, CREDIT_CNT=0, TIME_LEFT=0, ATTRACT=1, ATTRACT_N=0, GAME_ON=0, SCORE_CLR=0, GAME_END=0, debounced coin=0, debounce counter=0, edge registers=0.
- Coin debounce: sample COIN each edge. If the sample differs from the debounced level, increment the counter; otherwise clear it. When the counter reaches COIN_DEBOUNCE, flip the debounced level and clear the counter. This flip occurs on the COIN_DEBOUNCE-th consecutive differing edge. A 0->1 flip of the debounced level is a coin event.
- Credit update: CREDIT_CNT changes on the edge after the coin event.
  - Coin event alone: +1, saturating at MAX_CREDITS (excess coins lost).
  - Start acceptance alone: -1.
  - Coin event and start acceptance on the same edge: net 0, or -1+1 with saturation applied after the decrement, so 9 stays 9.
- Start detection: START registered each edge. A start edge is START=1 while the registered START=0. Holding START does not retrigger.
- States:
  - ATTRACT: a start edge with CREDIT_CNT>0 moves to CLEAR on the next edge and decrements credits. A start edge with 0 credits is ignored.
  - CLEAR: lasts exactly 1 cycle. SCORE_CLR=1 and TIME_LEFT loaded with GAME_FRAMES. Next edge goes to PLAY.
  - PLAY: GAME_ON=1, ATTRACT=0. Each VBLANK rising edge (registered edge detect, one-cycle latency) decrements TIME_LEFT. The decrement that makes TIME_LEFT 0 also moves the state to END, and GAME_END=1 for that following cycle. Start edges are ignored.
  - END: TIME_LEFT=0. An internal frame counter loaded with END_FRAMES decrements on VBLANK ticks. When it reaches 0, return to ATTRACT. Start edges are ignored.
- Coins are accepted and credited in every state.
- All outputs are registered, except ATTRACT_N, which is the inverse of the ATTRACT register.
- No arithmetic wraps: credits saturate at 0 and MAX_CREDITS, and timers stop at 0.

Test Plan:
- Coin debounce (COIN_DEBOUNCE=4): COIN high 3 cycles, low, then high 4 cycles.
  - Required: CREDIT_CNT stays 0 after the 3-cycle pulse.
  - Required: CREDIT_CNT becomes 1 on the edge after the 4th high sample.
  - Required: holding COIN high 100 cycles adds no further credit.
- Saturation: 11 clean coin pulses -> CREDIT_CNT=9. One more coin with a simultaneous start edge in ATTRACT -> CREDIT_CNT=9, state CLEAR.
- Start gating: start edge with 0 credits -> stays ATTRACT, SCORE_CLR never asserts. Add 1 coin, then start -> SCORE_CLR high for exactly 1 cycle, CREDIT_CNT=0, GAME_ON=1 on the following cycle.
- Game timer (GAME_FRAMES=5, END_FRAMES=2):
  - 5 VBLANK pulses -> TIME_LEFT goes 5,4,3,2,1,0.
  - GAME_END pulses once, GAME_ON drops.
  - After 2 more VBLANK pulses -> ATTRACT=1.
  - START held throughout causes no restart.
- Reset mid-PLAY (TIME_LEFT=3, CREDIT_CNT=2): RST_N low 1 cycle -> next edge all outputs at reset values, ATTRACT=1, CREDIT_CNT=0.
- Coin during PLAY: CREDIT_CNT 0->1 while GAME_ON stays 1. After END->ATTRACT, a start edge begins a new game.

Source files
------------

// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: coin/credit/start/game-time sequencer for the Space Race core.
// Debounces the coin switch, keeps a saturating credit count and steps the
// game through ATTRACT -> CLEAR -> PLAY -> END, producing the attract and
// game-on levels that gate the rocket, score and time-bar logic.
//
// Ports:
//   CLK_DRV    in   drive clock, all state changes on its rising edge
//   RST_N      in   synchronous active-low reset
//   COIN       in   raw coin switch level (active high)
//   START      in   start button level (active high)
//   VBLANK     in   vertical blank level, each 0->1 transition is a frame tick
//   CREDIT_CNT out  current credits (saturating 0..MAX_CREDITS)
//   ATTRACT    out  high in every state except PLAY
//   ATTRACT_N  out  inverse of ATTRACT
//   GAME_ON    out  high in PLAY only
//   SCORE_CLR  out  high for the single CLEAR cycle
//   GAME_END   out  one-cycle pulse following the PLAY->END transition
//   TIME_LEFT  out  remaining play frames, 0 outside CLEAR/PLAY
module game_seq_ctrl #(
  parameter int unsigned GAME_FRAMES   = 2700,
  parameter int unsigned END_FRAMES    = 120,
  parameter int unsigned COIN_DEBOUNCE = 4,
  parameter int unsigned MAX_CREDITS   = 9,
  parameter int unsigned TIME_WIDTH    = 12
) (
  input  logic                  CLK_DRV,
  input  logic                  RST_N,
  input  logic                  COIN,
  input  logic                  START,
  input  logic                  VBLANK,
  output logic [3:0]            CREDIT_CNT,
  output logic                  ATTRACT,
  output logic                  ATTRACT_N,
  output logic                  GAME_ON,
  output logic                  SCORE_CLR,
  output logic                  GAME_END,
  output logic [TIME_WIDTH-1:0] TIME_LEFT
);

  // Counter only needs to reach COIN_DEBOUNCE-1; the final differing edge flips.
  localparam int unsigned DB_W = (COIN_DEBOUNCE > 1) ? $clog2(COIN_DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]       DB_LAST    = DB_W'(COIN_DEBOUNCE - 1);
  localparam logic [3:0]            CREDIT_MAX = 4'(MAX_CREDITS);
  localparam logic [TIME_WIDTH-1:0] GAME_LOAD  = TIME_WIDTH'(GAME_FRAMES);
  localparam logic [TIME_WIDTH-1:0] END_LOAD   = TIME_WIDTH'(END_FRAMES);
  localparam logic [TIME_WIDTH-1:0] TIME_ONE   = TIME_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_coin_db;
  logic [DB_W-1:0]       r_db_cnt;
  logic                  r_coin_evt;
  logic                  r_start_q;
  logic                  r_vb_q;
  logic [3:0]            r_credit;
  logic [TIME_WIDTH-1:0] r_time;
  logic [TIME_WIDTH-1:0] r_end_cnt;
  logic                  r_attract;
  logic                  r_game_on;
  logic                  r_score_clr;
  logic                  r_game_end;

  state_t                w_state_nxt;
  logic [TIME_WIDTH-1:0] w_time_nxt;
  logic [TIME_WIDTH-1:0] w_end_cnt_nxt;
  logic                  w_game_end_nxt;
  logic                  w_start_edge;
  logic                  w_vb_tick;
  logic                  w_start_acc;
  logic [3:0]            w_credit_dec;
  logic [3:0]            w_credit_nxt;

  assign w_start_edge = START & ~r_start_q;
  assign w_vb_tick    = VBLANK & ~r_vb_q;
  assign w_start_acc  = (r_state == ST_ATTRACT) && w_start_edge && (r_credit != 4'd0);

  // Coin debounce; a rising flip of the debounced level is registered as a coin event.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      r_coin_db  <= 1'b0;
      r_db_cnt   <= '0;
      r_coin_evt <= 1'b0;
    end else begin
      r_coin_evt <= 1'b0;
      if (COIN != r_coin_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_coin_db  <= COIN;
          r_db_cnt   <= '0;
          r_coin_evt <= COIN;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Credit update: decrement for an accepted start first, then saturating coin add.
  always_comb begin
    w_credit_dec = r_credit;
    if (w_start_acc) begin
      w_credit_dec = r_credit - 4'd1;
    end
    w_credit_nxt = w_credit_dec;
    if (r_coin_evt && (w_credit_dec < CREDIT_MAX)) begin
      w_credit_nxt = w_credit_dec + 4'd1;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_time_nxt     = r_time;
    w_end_cnt_nxt  = r_end_cnt;
    w_game_end_nxt = 1'b0;
    case (r_state)
      ST_ATTRACT: begin
        if (w_start_acc) begin
          w_state_nxt = ST_CLEAR;
          w_time_nxt  = GAME_LOAD;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_vb_tick && (r_time != '0)) begin
          w_time_nxt = r_time - TIME_ONE;
          if (r_time == TIME_ONE) begin
            w_state_nxt    = ST_END;
            w_end_cnt_nxt  = END_LOAD;
            w_game_end_nxt = 1'b1;
          end
        end
      end
      ST_END: begin
        w_time_nxt = '0;
        if (r_end_cnt == '0) begin
          w_state_nxt = ST_ATTRACT;
        end else if (w_vb_tick) begin
          w_end_cnt_nxt = r_end_cnt - TIME_ONE;
          if (r_end_cnt == TIME_ONE) begin
            w_state_nxt = ST_ATTRACT;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ATTRACT;
      end
    endcase
  end

  // State, timers, edge detectors and registered outputs.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      r_state     <= ST_ATTRACT;
      r_start_q   <= 1'b0;
      r_vb_q      <= 1'b0;
      r_credit    <= 4'd0;
      r_time      <= '0;
      r_end_cnt   <= '0;
      r_attract   <= 1'b1;
      r_game_on   <= 1'b0;
      r_score_clr <= 1'b0;
      r_game_end  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_q   <= START;
      r_vb_q      <= VBLANK;
      r_credit    <= w_credit_nxt;
      r_time      <= w_time_nxt;
      r_end_cnt   <= w_end_cnt_nxt;
      r_attract   <= (w_state_nxt != ST_PLAY);
      r_game_on   <= (w_state_nxt == ST_PLAY);
      r_score_clr <= (w_state_nxt == ST_CLEAR);
      r_game_end  <= w_game_end_nxt;
    end
  end

  assign CREDIT_CNT = r_credit;
  assign ATTRACT    = r_attract;
  assign ATTRACT_N  = ~r_attract;
  assign GAME_ON    = r_game_on;
  assign SCORE_CLR  = r_score_clr;
  assign GAME_END   = r_game_end;
  assign TIME_LEFT  = r_time;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl: directed test-plan steps followed by randomized traffic,
// each cycle compared against a behavioural model of the sequencer rules.
module tb_game_seq_ctrl;

  localparam int unsigned TB_GAME  = 5;
  localparam int unsigned TB_END   = 2;
  localparam int unsigned TB_DEB   = 4;
  localparam int unsigned TB_MAXC  = 9;
  localparam int unsigned TB_TW    = 12;

  localparam int P_ATTRACT = 0;
  localparam int P_CLEAR   = 1;
  localparam int P_PLAY    = 2;
  localparam int P_END     = 3;

  logic             CLK_DRV = 1'b0;
  logic             RST_N   = 1'b0;
  logic             COIN    = 1'b0;
  logic             START   = 1'b0;
  logic             VBLANK  = 1'b0;
  logic [3:0]       CREDIT_CNT;
  logic             ATTRACT;
  logic             ATTRACT_N;
  logic             GAME_ON;
  logic             SCORE_CLR;
  logic             GAME_END;
  logic [TB_TW-1:0] TIME_LEFT;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int m_phase, m_credits, m_time, m_hold, m_db, m_run, m_pending;
  int m_prev_start, m_prev_vb, m_gend;

  game_seq_ctrl #(
    .GAME_FRAMES  (TB_GAME),
    .END_FRAMES   (TB_END),
    .COIN_DEBOUNCE(TB_DEB),
    .MAX_CREDITS  (TB_MAXC),
    .TIME_WIDTH   (TB_TW)
  ) dut (
    .CLK_DRV   (CLK_DRV),
    .RST_N     (RST_N),
    .COIN      (COIN),
    .START     (START),
    .VBLANK    (VBLANK),
    .CREDIT_CNT(CREDIT_CNT),
    .ATTRACT   (ATTRACT),
    .ATTRACT_N (ATTRACT_N),
    .GAME_ON   (GAME_ON),
    .SCORE_CLR (SCORE_CLR),
    .GAME_END  (GAME_END),
    .TIME_LEFT (TIME_LEFT)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the game rules, applied to the inputs sampled at that edge.
  task automatic model_step(input logic rn, input logic c, input logic s, input logic v);
    int start_edge;
    int accept;
    int tick;
    if (!rn) begin
      m_phase = P_ATTRACT; m_credits = 0; m_time = 0; m_hold = 0;
      m_db = 0; m_run = 0; m_pending = 0; m_prev_start = 0; m_prev_vb = 0; m_gend = 0;
      return;
    end
    start_edge = (s && m_prev_start == 0) ? 1 : 0;
    tick       = (v && m_prev_vb == 0) ? 1 : 0;
    accept     = (m_phase == P_ATTRACT && start_edge == 1 && m_credits > 0) ? 1 : 0;
    // credits: the coin seen on the previous edge lands now
    m_credits = m_credits - accept;
    if (m_pending == 1 && m_credits < int'(TB_MAXC)) m_credits = m_credits + 1;
    m_pending = 0;
    // debounce: TB_DEB consecutive disagreeing samples flip the level
    if (int'(c) != m_db) begin
      m_run = m_run + 1;
      if (m_run == int'(TB_DEB)) begin
        m_db = int'(c);
        m_run = 0;
        if (m_db == 1) m_pending = 1;
      end
    end else begin
      m_run = 0;
    end
    m_gend = 0;
    case (m_phase)
      P_ATTRACT: if (accept == 1) begin m_phase = P_CLEAR; m_time = int'(TB_GAME); end
      P_CLEAR:   m_phase = P_PLAY;
      P_PLAY:    if (tick == 1 && m_time > 0) begin
                   m_time = m_time - 1;
                   if (m_time == 0) begin m_phase = P_END; m_gend = 1; m_hold = int'(TB_END); end
                 end
      default: begin
        m_time = 0;
        if (m_hold == 0) m_phase = P_ATTRACT;
        else if (tick == 1) begin
          m_hold = m_hold - 1;
          if (m_hold == 0) m_phase = P_ATTRACT;
        end
      end
    endcase
    m_prev_start = int'(s);
    m_prev_vb    = int'(v);
  endtask

  task automatic check_all();
    chk("credit_cnt", 32'(CREDIT_CNT), m_credits);
    chk("attract",    32'(ATTRACT),    (m_phase != P_PLAY) ? 1 : 0);
    chk("attract_n",  32'(ATTRACT_N),  (m_phase != P_PLAY) ? 0 : 1);
    chk("game_on",    32'(GAME_ON),    (m_phase == P_PLAY) ? 1 : 0);
    chk("score_clr",  32'(SCORE_CLR),  (m_phase == P_CLEAR) ? 1 : 0);
    chk("game_end",   32'(GAME_END),   m_gend);
    chk("time_left",  32'(TIME_LEFT),  (m_phase == P_PLAY || m_phase == P_CLEAR) ? m_time : 0);
  endtask

  task automatic cyc(input logic rn, input logic c, input logic s, input logic v);
    RST_N = rn; COIN = c; START = s; VBLANK = v;
    @(posedge CLK_DRV);
    model_step(rn, c, s, v);
    #1;
    check_all();
  endtask

  // A clean coin insertion: long enough high and low to pass the debouncer.
  task automatic coin_pulse(input logic s, input logic v);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, s, v);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, s, v);
  endtask

  // One VBLANK pulse; the high cycle produces the tick.
  task automatic vb_pulse(input logic s);
    cyc(1'b1, 1'b0, s, 1'b1);
    cyc(1'b1, 1'b0, s, 1'b0);
  endtask

  initial begin
    logic rc, rs, rv, rr;

    // reset
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_credit", 32'(CREDIT_CNT), 0);
    chk("rst_attract", 32'(ATTRACT), 1);
    chk("rst_attract_n", 32'(ATTRACT_N), 0);
    chk("rst_time", 32'(TIME_LEFT), 0);

    // start with no credits is ignored
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("nocred_score_clr", 32'(SCORE_CLR), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("nocred_attract", 32'(ATTRACT), 1);
    chk("nocred_score_clr2", 32'(SCORE_CLR), 0);

    // debounce: 3-cycle pulse rejected
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("short_pulse_credit", 32'(CREDIT_CNT), 0);
    // 4 high samples flip the level, credit lands on the following edge
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("deb_4th_credit", 32'(CREDIT_CNT), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("deb_5th_credit", 32'(CREDIT_CNT), 1);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("deb_hold_credit", 32'(CREDIT_CNT), 1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // accepted start: one CLEAR cycle, then PLAY
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_score_clr", 32'(SCORE_CLR), 1);
    chk("clr_credit", 32'(CREDIT_CNT), 0);
    chk("clr_time", 32'(TIME_LEFT), TB_GAME);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("play_score_clr", 32'(SCORE_CLR), 0);
    chk("play_game_on", 32'(GAME_ON), 1);
    chk("play_attract", 32'(ATTRACT), 0);

    // game timer with START held; coin accepted mid-game
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      chk("timer_time", 32'(TIME_LEFT), TB_GAME - i);
      if (i < 5) begin
        chk("timer_game_on", 32'(GAME_ON), 1);
        chk("timer_game_end_lo", 32'(GAME_END), 0);
      end
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        coin_pulse(1'b1, 1'b0);
        chk("play_coin_credit", 32'(CREDIT_CNT), 1);
        chk("play_coin_game_on", 32'(GAME_ON), 1);
        chk("play_coin_time", 32'(TIME_LEFT), 3);
      end
    end
    // back up to the final tick edge results via explicit checks above;
    // the GAME_END pulse already dropped after the trailing low cycle
    chk("end_game_end_dropped", 32'(GAME_END), 0);
    chk("end_game_on", 32'(GAME_ON), 0);
    chk("end_attract", 32'(ATTRACT), 1);

    // start edge during END is ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("end_start_score_clr", 32'(SCORE_CLR), 0);
    chk("end_start_credit", 32'(CREDIT_CNT), 1);
    vb_pulse(1'b1);
    vb_pulse(1'b1);
    chk("attract_back", 32'(ATTRACT), 1);
    // held START in ATTRACT does not restart
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("held_start_score_clr", 32'(SCORE_CLR), 0);
    chk("held_start_credit", 32'(CREDIT_CNT), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_score_clr", 32'(SCORE_CLR), 1);
    chk("restart_credit", 32'(CREDIT_CNT), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_game_on", 32'(GAME_ON), 1);

    // reset mid-PLAY with TIME_LEFT=3 and two credits
    coin_pulse(1'b0, 1'b0);
    coin_pulse(1'b0, 1'b0);
    vb_pulse(1'b0);
    vb_pulse(1'b0);
    chk("pre_rst_time", 32'(TIME_LEFT), 3);
    chk("pre_rst_credit", 32'(CREDIT_CNT), 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_credit", 32'(CREDIT_CNT), 0);
    chk("midrst_attract", 32'(ATTRACT), 1);
    chk("midrst_game_on", 32'(GAME_ON), 0);
    chk("midrst_time", 32'(TIME_LEFT), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // saturation, then coin landing on the same edge as an accepted start
    for (int i = 0; i < 11; i++) coin_pulse(1'b0, 1'b0);
    chk("sat_credit", 32'(CREDIT_CNT), TB_MAXC);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_start_credit", 32'(CREDIT_CNT), TB_MAXC);
    chk("sat_start_score_clr", 32'(SCORE_CLR), 1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // randomized traffic against the model
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rc = 1'b0; rs = 1'b0; rv = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 5) == 0) rc = ~rc;
      if ($urandom_range(0, 7) == 0) rs = ~rs;
      if ($urandom_range(0, 2) == 0) rv = ~rv;
      rr = ($urandom_range(0, 999) != 0);
      cyc(rr, rc, rs, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
